mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/riscv_pkg.sv | 78 +++++++
 rtl/alu_decoder.sv | 43 ++++
 rtl/mc_controller.sv | 206 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the multi-cycle RISC-V controller: opcodes, FSM state encodings,
// ALUControl codes and datapath mux selects.
package riscv_pkg;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9,
    StJal    = 4'd10,
    StJalr   = 4'd11,
    StUpper  = 4'd12,
    StHalt   = 4'd13
  } state_e;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluXor = 3'b100,
    AluSlt = 3'b101,
    AluSll = 3'b110,
    AluSrl = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_e;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResMem    = 2'b01;
  localparam logic [1:0] ResAluRes = 2'b10;
  localparam logic [1:0] ResImm    = 2'b11;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmU = 3'b011;
  localparam logic [2:0] ImmJ = 3'b100;

  function automatic logic [2:0] imm_sel(input logic [6:0] opcode);
    case (opcode)
      OpStore:         return ImmS;
      OpBranch:        return ImmB;
      OpLui, OpAuipc:  return ImmU;
      OpJal:           return ImmJ;
      default:         return ImmI;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the requested ALU operation (fixed add/sub or instruction-defined) to ALUControl,
// and flags R/I arithmetic encodings the ALU cannot execute.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic       is_rtype_i,
  input  logic [2:0] func3_i,
  input  logic [6:0] func7_i,
  output logic [2:0] alu_ctrl_o,
  output logic       illegal_o
);

  logic is_sub;
  logic is_shift;

  always_comb begin
    is_sub   = is_rtype_i && (func3_i == 3'b000) && func7_i[5];
    is_shift = (func3_i == 3'b001) || (func3_i == 3'b101);
    // sltu has no ALU code; non-zero func7 is only meaningful for sub (shift imm must be < 32)
    illegal_o = (func3_i == 3'b011) ||
                ((func7_i != 7'd0) && !is_sub && (is_rtype_i || is_shift));

    alu_ctrl_o = AluAdd;
    unique case (alu_op_i)
      AluOpSub: alu_ctrl_o = AluSub;
      AluOpFunct: begin
        unique case (func3_i)
          3'b000:  alu_ctrl_o = is_sub ? AluSub : AluAdd;
          3'b001:  alu_ctrl_o = AluSll;
          3'b010:  alu_ctrl_o = AluSlt;
          3'b100:  alu_ctrl_o = AluXor;
          3'b101:  alu_ctrl_o = AluSrl;
          3'b110:  alu_ctrl_o = AluOr;
          3'b111:  alu_ctrl_o = AluAnd;
          default: alu_ctrl_o = AluAdd;
        endcase
      end
      default: alu_ctrl_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RISC-V control FSM with bounded memory waits and a sticky fault/HALT state.
module mc_controller
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic [3:0] state_dbg,
  output logic       fault
);

  localparam int unsigned CntW = $clog2(MEM_WAIT_MAX + 1) + 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_q, wait_d;
  logic            fault_q, fault_d;

  logic       is_wait;
  logic       timeout;
  logic       is_rtype;
  logic       illegal;
  logic [1:0] alu_op;

  assign is_rtype = (opcode == OpRtype);

  alu_decoder u_alu_decoder (
    .alu_op_i   (alu_op),
    .is_rtype_i (is_rtype),
    .func3_i    (func3),
    .func7_i    (func7),
    .alu_ctrl_o (ALUControl),
    .illegal_o  (illegal)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    is_wait = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    // wait_q counts earlier idle cycles, so this fires on idle cycle MEM_WAIT_MAX+1
    timeout = is_wait && !mem_ready && (wait_q == CntW'(MEM_WAIT_MAX));
    if (is_wait && !mem_ready && !timeout) begin
      wait_d = wait_q + 1'b1;
    end

    unique case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = illegal ? StHalt : StExecR;
          OpItype:         state_d = illegal ? StHalt : StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui, OpAuipc:  state_d = StUpper;
          default:         state_d = StHalt;
        endcase
      end
      StMemAdr: state_d = (opcode == OpStore) ? StMemWr : StMemRd;
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StExecR,
      StExecI:  state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = (func3 == 3'b000 || func3 == 3'b001) ? StFetch : StHalt;
      StJal,
      StJalr,
      StUpper:  state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StHalt;
    endcase

    if (timeout) begin
      state_d = StHalt;
    end
    fault_d = fault_q || (state_d == StHalt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = SrcAPc;
    ALUSrcB   = SrcBRs2;
    ResultSrc = ResAluOut;
    ImmSrc    = imm_sel(opcode);
    alu_op    = AluOpAdd;

    unique case (state_q)
      StFetch: begin
        MemRead   = 1'b1;
        ALUSrcA   = SrcAPc;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluRes;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      StDecode: begin
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBImm;
      end
      StMemAdr: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBImm;
      end
      StMemRd: begin
        MemRead = 1'b1;
        AdrSrc  = 1'b1;
      end
      StMemWb: begin
        RegWrite  = 1'b1;
        ResultSrc = ResMem;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      StExecR: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBRs2;
        alu_op  = AluOpFunct;
      end
      StExecI: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBImm;
        alu_op  = AluOpFunct;
      end
      StAluWb: begin
        RegWrite  = 1'b1;
        ResultSrc = ResAluOut;
      end
      StBranch: begin
        ALUSrcA   = SrcARs1;
        ALUSrcB   = SrcBRs2;
        alu_op    = AluOpSub;
        ResultSrc = ResAluOut;
        PCWrite   = ((func3 == 3'b000) && zero) || ((func3 == 3'b001) && !zero);
      end
      StJal: begin
        // ALU forms the link value PC+4; the jump target was latched in DECODE
        ALUSrcA   = SrcAOldPc;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluOut;
        RegWrite  = 1'b1;
        PCWrite   = 1'b1;
      end
      StJalr: begin
        ALUSrcA   = SrcARs1;
        ALUSrcB   = SrcBImm;
        ResultSrc = ResAluRes;
        RegWrite  = 1'b1;
        PCWrite   = 1'b1;
      end
      StUpper: begin
        RegWrite  = 1'b1;
        ResultSrc = (opcode == OpLui) ? ResImm : ResAluOut;
      end
      default: ;
    endcase

    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign state_dbg = state_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed vector table, hand-written multi-cycle corner cases and a
// randomized run against an instruction-level model.
module tb_mc_controller;
  import riscv_pkg::*;

  localparam int unsigned MaxWait = 15;

  localparam logic [31:0] IAdd  = 32'h002081B3;
  localparam logic [31:0] ISub  = 32'h402081B3;
  localparam logic [31:0] IAndi = 32'h0050F193;
  localparam logic [31:0] IBeq  = 32'h00208063;
  localparam logic [31:0] IBne  = 32'h00209063;
  localparam logic [31:0] IBbad = 32'h0020A063;
  localparam logic [31:0] IJal  = 32'h0000006F;
  localparam logic [31:0] ILui  = 32'h000001B7;
  localparam logic [31:0] ILw   = 32'h0000A183;
  localparam logic [31:0] ISw   = 32'h0020A023;
  localparam logic [31:0] IBad  = 32'h0000007F;

  // {PCWrite, IRWrite, MemRead, MemWrite, RegWrite}
  localparam logic [4:0] WF  = 5'b11100;
  localparam logic [4:0] WFw = 5'b00100;
  localparam logic [4:0] W0  = 5'b00000;
  localparam logic [4:0] WRw = 5'b00001;
  localparam logic [4:0] WMr = 5'b00100;
  localparam logic [4:0] WMw = 5'b00010;
  localparam logic [4:0] WJ  = 5'b10001;
  localparam logic [4:0] WPc = 5'b10000;

  logic clk = 1'b0;
  logic rst, zero, mem_ready;
  logic [31:0] instr;
  logic [6:0] opcode, func7;
  logic [2:0] func3;
  logic PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite, fault;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ALUControl, ImmSrc;
  logic [3:0] state_dbg;
  logic [4:0] we;

  assign opcode = instr[6:0];
  assign func3  = instr[14:12];
  assign func7  = instr[31:25];
  assign we     = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite};

  always #5 clk = ~clk;

  mc_controller #(.MEM_WAIT_MAX(MaxWait)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .func3      (func3),
    .func7      (func7),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .state_dbg  (state_dbg),
    .fault      (fault)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic        mr;
    logic        z;
    state_e      st;
    logic [4:0]  w;
    logic        ca;
    logic [2:0]  al;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Called just after a rising edge; drives one cycle, checks mid-cycle, returns after next edge.
  task automatic cyc(input string n, input logic r, input logic [31:0] ins, input logic mr,
                     input logic z, input state_e st, input logic [4:0] w, input logic f,
                     input logic ca, input logic [2:0] al);
    rst = r; instr = ins; mem_ready = mr; zero = z;
    #3;
    check(n, {6'd0, state_dbg, we, fault}, {6'd0, st, w, f});
    if (ca) check({n, "_alu"}, {13'd0, ALUControl}, {13'd0, al});
    @(posedge clk);
    #1;
  endtask

  task automatic v(input string n, input logic [31:0] ins, input logic mr, input logic z,
                   input state_e st, input logic [4:0] w, input logic ca, input logic [2:0] al);
    tbl.push_back('{n, ins, mr, z, st, w, ca, al});
  endtask

  // ---------------- behavioural model ----------------
  state_e      m_st;
  state_e      path[$];
  int unsigned m_wait;
  logic        m_fault;

  // Expected state sequence after FETCH for one instruction, straight from the ISA rules.
  task automatic plan(input logic [31:0] ins);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    path.delete();
    path.push_back(StDecode);
    case (op)
      OpLoad:   begin path.push_back(StMemAdr); path.push_back(StMemRd); path.push_back(StMemWb); end
      OpStore:  begin path.push_back(StMemAdr); path.push_back(StMemWr); end
      OpRtype:  if (f3 != 3 && (f7 == 0 || (f3 == 0 && f7 == 7'h20) || (f3 == 0 && f7[5]))) begin
                  path.push_back(StExecR); path.push_back(StAluWb);
                end else path.push_back(StHalt);
      OpItype:  if (f3 != 3 && ((f3 != 1 && f3 != 5) || f7 == 0)) begin
                  path.push_back(StExecI); path.push_back(StAluWb);
                end else path.push_back(StHalt);
      OpBranch: begin
                  path.push_back(StBranch);
                  if (f3 > 1) path.push_back(StHalt);
                end
      OpJal:    path.push_back(StJal);
      OpJalr:   path.push_back(StJalr);
      OpLui, OpAuipc: path.push_back(StUpper);
      default:  path.push_back(StHalt);
    endcase
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [0:9];
    logic [31:0] ins;
    int k;
    ops = '{OpLoad, OpStore, OpRtype, OpItype, OpBranch, OpJal, OpJalr, OpLui, OpAuipc, 7'h7F};
    ins = $urandom();
    ins[6:0] = ops[$urandom_range(9)];
    k = $urandom_range(9);
    if (k < 6) ins[31:25] = 7'd0;
    else if (k < 8) ins[31:25] = 7'h20;
    if (ins[6:0] == OpBranch && $urandom_range(3) != 0) ins[14:12] = {2'b00, 1'($urandom_range(1))};
    return ins;
  endfunction

  initial begin
    logic [2:0] alu_tbl [0:7];
    logic        r, mr, z, taken, ca;
    logic [2:0]  exp_alu;
    logic [4:0]  exp_w;
    logic [31:0] ins;
    int          stall_left, halt_cyc;

    rst = 1'b1; instr = IAdd; mem_ready = 1'b0; zero = 1'b0;
    #3;
    check("reset_we", {11'd0, we}, 16'd0);
    @(posedge clk);
    #1;

    // ---------------- directed vector table ----------------
    v("add_fetch", IAdd, 1, 0, StFetch, WF, 1, AluAdd);
    v("add_decode", IAdd, 0, 0, StDecode, W0, 0, 0);
    v("add_execr", IAdd, 1, 0, StExecR, W0, 1, AluAdd);
    v("add_aluwb", IAdd, 1, 0, StAluWb, WRw, 0, 0);
    v("sub_fetch", ISub, 1, 0, StFetch, WF, 0, 0);
    v("sub_decode", ISub, 1, 0, StDecode, W0, 0, 0);
    v("sub_execr", ISub, 1, 0, StExecR, W0, 1, AluSub);
    v("sub_aluwb", ISub, 0, 0, StAluWb, WRw, 0, 0);
    v("andi_fetch", IAndi, 1, 0, StFetch, WF, 0, 0);
    v("andi_decode", IAndi, 1, 0, StDecode, W0, 0, 0);
    v("andi_execi", IAndi, 1, 0, StExecI, W0, 1, AluAnd);
    v("andi_aluwb", IAndi, 1, 0, StAluWb, WRw, 0, 0);
    v("beq1_fetch", IBeq, 1, 0, StFetch, WF, 0, 0);
    v("beq1_decode", IBeq, 1, 1, StDecode, W0, 0, 0);
    v("beq1_branch", IBeq, 1, 1, StBranch, WPc, 1, AluSub);
    v("beq0_fetch", IBeq, 1, 0, StFetch, WF, 0, 0);
    v("beq0_decode", IBeq, 1, 0, StDecode, W0, 0, 0);
    v("beq0_branch", IBeq, 1, 0, StBranch, W0, 1, AluSub);
    v("bne0_fetch", IBne, 1, 0, StFetch, WF, 0, 0);
    v("bne0_decode", IBne, 1, 0, StDecode, W0, 0, 0);
    v("bne0_branch", IBne, 0, 0, StBranch, WPc, 1, AluSub);
    v("jal_fetch", IJal, 1, 0, StFetch, WF, 0, 0);
    v("jal_decode", IJal, 1, 0, StDecode, W0, 0, 0);
    v("jal_jal", IJal, 1, 0, StJal, WJ, 0, 0);
    v("lui_fetch", ILui, 1, 0, StFetch, WF, 0, 0);
    v("lui_decode", ILui, 1, 0, StDecode, W0, 0, 0);
    v("lui_upper", ILui, 1, 0, StUpper, WRw, 0, 0);
    v("add2_fetch", IAdd, 1, 0, StFetch, WF, 0, 0);
    v("add2_decode", IAdd, 1, 0, StDecode, W0, 0, 0);
    v("add2_execr", IAdd, 1, 0, StExecR, W0, 1, AluAdd);
    v("add2_aluwb", IAdd, 1, 0, StAluWb, WRw, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].name, 1'b0, tbl[i].ins, tbl[i].mr, tbl[i].z, tbl[i].st, tbl[i].w, 1'b0,
          tbl[i].ca, tbl[i].al);
    end

    // ---------------- lw with 3 stalled MEMRD cycles ----------------
    cyc("lw_fetch", 0, ILw, 1, 0, StFetch, WF, 0, 0, 0);
    cyc("lw_decode", 0, ILw, 1, 0, StDecode, W0, 0, 0, 0);
    cyc("lw_memadr", 0, ILw, 1, 0, StMemAdr, W0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("lw_memrd_wait", 0, ILw, 0, 0, StMemRd, WMr, 0, 0, 0);
    cyc("lw_memrd_ready", 0, ILw, 1, 0, StMemRd, WMr, 0, 0, 0);
    cyc("lw_memwb", 0, ILw, 0, 0, StMemWb, WRw, 0, 0, 0);

    // ---------------- 15 idle FETCH cycles is still within budget ----------------
    for (int i = 0; i < 15; i++) cyc("fetch_wait15", 0, IAdd, 0, 0, StFetch, WFw, 0, 0, 0);
    cyc("fetch_ready16", 0, IAdd, 1, 0, StFetch, WF, 0, 0, 0);
    cyc("wait15_decode", 0, IAdd, 1, 0, StDecode, W0, 0, 0, 0);
    cyc("wait15_execr", 0, IAdd, 1, 0, StExecR, W0, 0, 0, 0);
    cyc("wait15_aluwb", 0, IAdd, 1, 0, StAluWb, WRw, 0, 0, 0);

    // ---------------- reset in the middle of a store ----------------
    cyc("sw_fetch", 0, ISw, 1, 0, StFetch, WF, 0, 0, 0);
    cyc("sw_decode", 0, ISw, 1, 0, StDecode, W0, 0, 0, 0);
    cyc("sw_memadr", 0, ISw, 1, 0, StMemAdr, W0, 0, 0, 0);
    cyc("sw_memwr_wait", 0, ISw, 0, 0, StMemWr, WMw, 0, 0, 0);
    cyc("sw_memwr_rst", 1, ISw, 1, 0, StMemWr, W0, 0, 0, 0);

    // ---------------- branch with unsupported func3 ----------------
    cyc("bbad_fetch", 0, IBbad, 1, 0, StFetch, WF, 0, 0, 0);
    cyc("bbad_decode", 0, IBbad, 1, 1, StDecode, W0, 0, 0, 0);
    cyc("bbad_branch", 0, IBbad, 1, 1, StBranch, W0, 0, 0, 0);
    cyc("bbad_halt", 0, IBbad, 1, 1, StHalt, W0, 1, 0, 0);
    cyc("bbad_rst", 1, IBbad, 1, 1, StHalt, W0, 1, 0, 0);

    // ---------------- illegal opcode ----------------
    cyc("ill_fetch", 0, IBad, 1, 0, StFetch, WF, 0, 0, 0);
    cyc("ill_decode", 0, IBad, 1, 0, StDecode, W0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("ill_halt", 0, IBad, 1, 0, StHalt, W0, 1, 0, 0);
    cyc("ill_rst", 1, IBad, 1, 0, StHalt, W0, 1, 0, 0);

    // ---------------- FETCH timeout after 16 idle cycles ----------------
    for (int i = 0; i < 16; i++) cyc("to_fetch_wait", 0, IAdd, 0, 0, StFetch, WFw, 0, 0, 0);
    cyc("to_halt", 0, IAdd, 1, 0, StHalt, W0, 1, 0, 0);
    cyc("to_halt_hold", 0, IAdd, 0, 0, StHalt, W0, 1, 0, 0);
    cyc("to_rst", 1, IAdd, 1, 0, StHalt, W0, 1, 0, 0);

    // ---------------- randomized run against the model ----------------
    alu_tbl = '{AluAdd, AluSll, AluSlt, AluAdd, AluXor, AluSrl, AluOr, AluAnd};
    m_st = StFetch; m_wait = 0; m_fault = 1'b0; path.delete();
    stall_left = 0; halt_cyc = 0;
    ins = rand_instr();
    for (int c = 0; c < 3000; c++) begin
      if (m_st == StFetch) ins = rand_instr();
      if (stall_left > 0) begin
        mr = 1'b0;
        stall_left--;
      end else begin
        mr = ($urandom_range(99) < 75);
        if ($urandom_range(149) == 0) stall_left = $urandom_range(20, 12);
      end
      z = 1'($urandom_range(1));
      r = ($urandom_range(99) < 2) || (halt_cyc > 2);
      rst = r; instr = ins; mem_ready = mr; zero = z;

      taken = (ins[14:12] == 3'd0 && z) || (ins[14:12] == 3'd1 && !z);
      exp_w = W0;
      if (!r) begin
        case (m_st)
          StFetch:                   exp_w = {mr, mr, 1'b1, 2'b00};
          StMemRd:                   exp_w = WMr;
          StMemWr:                   exp_w = WMw;
          StMemWb, StAluWb, StUpper: exp_w = WRw;
          StJal, StJalr:             exp_w = WJ;
          StBranch:                  exp_w = {taken, 4'b0000};
          default:                   exp_w = W0;
        endcase
      end
      ca = 1'b1;
      case (m_st)
        StFetch:  exp_alu = AluAdd;
        StBranch: exp_alu = AluSub;
        StExecR:  exp_alu = (ins[14:12] == 3'd0 && ins[30]) ? AluSub : alu_tbl[ins[14:12]];
        StExecI:  exp_alu = alu_tbl[ins[14:12]];
        default:  begin exp_alu = AluAdd; ca = 1'b0; end
      endcase

      #3;
      check("rand", {6'd0, state_dbg, we, fault}, {6'd0, m_st, exp_w, m_fault});
      if (ca) check("rand_alu", {13'd0, ALUControl}, {13'd0, exp_alu});

      if (r) begin
        m_st = StFetch; m_wait = 0; m_fault = 1'b0; path.delete();
      end else if (m_st != StHalt) begin
        if ((m_st == StFetch || m_st == StMemRd || m_st == StMemWr) && !mr) begin
          m_wait++;
          if (m_wait > MaxWait) m_st = StHalt;
        end else begin
          m_wait = 0;
          if (m_st == StFetch) plan(ins);
          m_st = (path.size() > 0) ? path.pop_front() : StFetch;
        end
        if (m_st == StHalt) m_fault = 1'b1;
      end
      halt_cyc = (m_st == StHalt) ? halt_cyc + 1 : 0;

      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
